minirisc_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the MiniRISC 8-bit soft CPU.
- Fetches instructions over a req/ack instruction-memory port and holds them in an instruction register.
- Drives the 4x8 register file read selects, write select, write enable and writeback-mux select, plus ALU and data-memory controls.
- Owns the PC. Sits between instruction memory, data memory and the register file/ALU datapath.

---
 rtl/minirisc_control_fsm.sv | 136 +++++++++++++
 tb/tb_minirisc_control_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/minirisc_control_fsm.sv
// Multi-cycle control sequencer for the MiniRISC 8-bit CPU: fetch over a
// req/ack port, decode, then ALU, memory or branch step, with PC ownership.
module minirisc_control_fsm #(
    parameter int                    PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    output logic                o_IMem_Req,
    output logic [PC_WIDTH-1:0] o_IMem_Addr,
    input  logic                i_IMem_Ack,
    input  logic [7:0]          i_IMem_Data,
    input  logic [7:0]          i_Read_Data_1,
    output logic [1:0]          o_Reg1,
    output logic [2:0]          o_Reg_Imm,
    output logic [1:0]          o_Write_Sel,
    output logic                o_Write_En,
    output logic                o_UseMem,
    output logic [1:0]          o_Alu_Op,
    output logic                o_Alu_Src_Imm,
    output logic                o_DMem_Req,
    output logic                o_DMem_We,
    input  logic                i_DMem_Ack,
    output logic                o_Retire,
    output logic                o_Halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_HALT
    } state_t;

    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_BNZ  = 3'b111;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic [7:0]          ir, ir_next;
    logic [2:0]          opcode;
    logic [PC_WIDTH-1:0] imm_sext;

    assign opcode   = ir[7:5];
    assign imm_sext = {{(PC_WIDTH-3){ir[2]}}, ir[2:0]};

    // IR only changes on a fetch ack, so the selects stay stable until retire.
    assign o_IMem_Addr = pc;
    assign o_Reg1      = ir[4:3];
    assign o_Write_Sel = ir[4:3];
    assign o_Reg_Imm   = ir[2:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            S_FETCH: begin
                if (i_IMem_Ack) begin
                    ir_next    = i_IMem_Data;
                    pc_next    = pc + PC_WIDTH'(1);
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_BNZ)
                    state_next = (ir[2:0] == 3'b000) ? S_HALT : S_BRANCH;
                else if (opcode == OP_LD || opcode == OP_ST)
                    state_next = S_MEM;
                else
                    state_next = S_EXEC;
            end
            S_EXEC:   state_next = S_FETCH;
            S_MEM:    if (i_DMem_Ack) state_next = S_FETCH;
            S_BRANCH: begin
                // pc already points past the branch; offset wraps modulo 2^PC_WIDTH.
                if (i_Read_Data_1 != 8'h00) pc_next = pc + imm_sext;
                state_next = S_FETCH;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Reset gates every strobe so an ack landing in the reset cycle does nothing.
    always_comb begin
        o_IMem_Req    = 1'b0;
        o_Write_En    = 1'b0;
        o_UseMem      = 1'b0;
        o_Alu_Op      = 2'b00;
        o_Alu_Src_Imm = 1'b0;
        o_DMem_Req    = 1'b0;
        o_DMem_We     = 1'b0;
        o_Retire      = 1'b0;
        o_Halted      = 1'b0;
        if (!i_Reset) begin
            case (state)
                S_FETCH: o_IMem_Req = 1'b1;
                S_EXEC: begin
                    o_Alu_Op      = (opcode == OP_ADDI) ? 2'b00 : opcode[1:0];
                    o_Alu_Src_Imm = (opcode == OP_ADDI);
                    o_Write_En    = 1'b1;
                    o_Retire      = 1'b1;
                end
                S_MEM: begin
                    o_DMem_Req = 1'b1;
                    o_DMem_We  = (opcode == OP_ST);
                    if (i_DMem_Ack) begin
                        o_Retire   = 1'b1;
                        o_Write_En = (opcode == OP_LD);
                        o_UseMem   = (opcode == OP_LD);
                    end
                end
                S_BRANCH: o_Retire = 1'b1;
                S_HALT:   o_Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minirisc_control_fsm.sv
// Directed bench for minirisc_control_fsm: a cycle-by-cycle vector table for a
// short program, plus hand-written sequences for waits, wrap, halt and reset.
module tb_minirisc_control_fsm;

    typedef struct packed {
        logic       imem_req;
        logic [7:0] imem_addr;
        logic       write_en;
        logic       use_mem;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       dmem_req;
        logic       dmem_we;
        logic       retire;
        logic       halted;
        logic [1:0] write_sel;
        logic [1:0] reg1;
        logic [2:0] reg_imm;
    } outs_t;

    typedef struct {
        logic       iack;
        logic [7:0] idata;
        logic       dack;
        logic [7:0] rd1;
        outs_t      exp;
    } vec_t;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_IMem_Ack = 1'b0;
    logic [7:0] i_IMem_Data = 8'h00;
    logic [7:0] i_Read_Data_1 = 8'h00;
    logic       i_DMem_Ack = 1'b0;
    logic       o_IMem_Req, o_Write_En, o_UseMem, o_Alu_Src_Imm;
    logic       o_DMem_Req, o_DMem_We, o_Retire, o_Halted;
    logic [7:0] o_IMem_Addr;
    logic [1:0] o_Reg1, o_Write_Sel, o_Alu_Op;
    logic [2:0] o_Reg_Imm;

    int errors = 0;
    int checks = 0;
    vec_t tbl[28];

    always #5 i_Clk = ~i_Clk;

    minirisc_control_fsm #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .o_IMem_Req(o_IMem_Req), .o_IMem_Addr(o_IMem_Addr),
        .i_IMem_Ack(i_IMem_Ack), .i_IMem_Data(i_IMem_Data),
        .i_Read_Data_1(i_Read_Data_1),
        .o_Reg1(o_Reg1), .o_Reg_Imm(o_Reg_Imm), .o_Write_Sel(o_Write_Sel),
        .o_Write_En(o_Write_En), .o_UseMem(o_UseMem), .o_Alu_Op(o_Alu_Op),
        .o_Alu_Src_Imm(o_Alu_Src_Imm), .o_DMem_Req(o_DMem_Req),
        .o_DMem_We(o_DMem_We), .i_DMem_Ack(i_DMem_Ack),
        .o_Retire(o_Retire), .o_Halted(o_Halted)
    );

    // Expected outputs; reg1 mirrors the write select field.
    function automatic outs_t e(input logic req, input logic [7:0] addr,
                                input logic wen, input logic um,
                                input logic [1:0] aop, input logic simm,
                                input logic dreq, input logic dwe,
                                input logic ret, input logic halt,
                                input logic [1:0] ws, input logic [2:0] ri);
        outs_t o;
        o = '{req, addr, wen, um, aop, simm, dreq, dwe, ret, halt, ws, ws, ri};
        return o;
    endfunction

    function automatic vec_t v(input logic iack, input logic [7:0] idata,
                               input logic dack, input logic [7:0] rd1,
                               input outs_t exp);
        vec_t r;
        r.iack = iack; r.idata = idata; r.dack = dack; r.rd1 = rd1; r.exp = exp;
        return r;
    endfunction

    // Store direction only matters while a data request is up.
    function automatic outs_t sample();
        outs_t o;
        o = '{o_IMem_Req, o_IMem_Addr, o_Write_En, o_UseMem, o_Alu_Op,
              o_Alu_Src_Imm, o_DMem_Req, o_DMem_We & o_DMem_Req, o_Retire,
              o_Halted, o_Write_Sel, o_Reg1, o_Reg_Imm};
        return o;
    endfunction

    // Applies inputs just after a rising edge and leaves time for them to settle.
    task automatic drive(input logic rst, input logic iack, input logic [7:0] idata,
                         input logic dack, input logic [7:0] rd1);
        @(posedge i_Clk);
        #1;
        i_Reset = rst; i_IMem_Ack = iack; i_IMem_Data = idata;
        i_DMem_Ack = dack; i_Read_Data_1 = rd1;
        #2;
    endtask

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        // ADD R0,R1 / AND R1,R1 / ST R1,[R3] / SUB R3,R0 / BNZ taken /
        // OR R2,R1 / BNZ not taken / LD R1,[R3] with two wait cycles.
        tbl[0]  = v(1, 8'h01, 0, 8'h00, e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = v(0, 8'h00, 0, 8'h00, e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        tbl[2]  = v(0, 8'h00, 0, 8'h00, e(0, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1));
        tbl[3]  = v(1, 8'h4E, 0, 8'h00, e(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        tbl[4]  = v(0, 8'h00, 0, 8'h00, e(0, 2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 6));
        tbl[5]  = v(0, 8'h00, 0, 8'h00, e(0, 2, 1, 0, 2'b10, 0, 0, 0, 1, 0, 1, 6));
        tbl[6]  = v(1, 8'hCB, 0, 8'h00, e(1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 6));
        tbl[7]  = v(0, 8'h00, 0, 8'h00, e(0, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));
        tbl[8]  = v(0, 8'h00, 1, 8'h00, e(0, 3, 0, 0, 2'b00, 0, 1, 1, 1, 0, 1, 3));
        tbl[9]  = v(1, 8'h38, 0, 8'h00, e(1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));
        tbl[10] = v(0, 8'h00, 0, 8'h00, e(0, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0));
        tbl[11] = v(0, 8'h00, 0, 8'h00, e(0, 4, 1, 0, 2'b01, 0, 0, 0, 1, 0, 3, 0));
        tbl[12] = v(1, 8'hE6, 0, 8'h00, e(1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0));
        tbl[13] = v(0, 8'h00, 0, 8'h00, e(0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        tbl[14] = v(0, 8'h00, 0, 8'h07, e(0, 5, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 6));
        tbl[15] = v(1, 8'h71, 0, 8'h00, e(1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        tbl[16] = v(0, 8'h00, 0, 8'h00, e(0, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 1));
        tbl[17] = v(0, 8'h00, 0, 8'h00, e(0, 4, 1, 0, 2'b11, 0, 0, 0, 1, 0, 2, 1));
        tbl[18] = v(1, 8'hE6, 0, 8'h00, e(1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 1));
        tbl[19] = v(0, 8'h00, 0, 8'h00, e(0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        tbl[20] = v(0, 8'h00, 0, 8'h00, e(0, 5, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 6));
        tbl[21] = v(0, 8'h00, 1, 8'h00, e(1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        tbl[22] = v(1, 8'hAB, 0, 8'h00, e(1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        tbl[23] = v(0, 8'h00, 0, 8'h00, e(0, 6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));
        tbl[24] = v(0, 8'h00, 0, 8'h00, e(0, 6, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1, 3));
        tbl[25] = v(0, 8'h00, 0, 8'h00, e(0, 6, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1, 3));
        tbl[26] = v(0, 8'h00, 1, 8'h00, e(0, 6, 1, 1, 2'b00, 0, 1, 0, 1, 0, 1, 3));
        tbl[27] = v(0, 8'h00, 0, 8'h00, e(1, 6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));

        // Reset state, with a stray fetch ack that must not be taken.
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00);
        check("reset_state", e(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].iack, tbl[i].idata, tbl[i].dack, tbl[i].rd1);
            check($sformatf("vec[%0d]", i), tbl[i].exp);
        end

        // ADDI R2,#5 with fetch ack three cycles late: retire lands on cycle 5.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 8'h95, 1'b0, 8'h00);
            check($sformatf("addi_fetch_hold[%0d]", i),
                  e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("addi_decode", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 5));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("addi_exec", e(0, 1, 1, 0, 2'b00, 1, 0, 0, 1, 0, 2, 5));

        // BNZ #-2 at PC 0 lands on 255, then BNZ #+1 there wraps to 1.
        pulse_reset();
        drive(1'b0, 1'b1, 8'hE6, 1'b0, 8'h00);
        check("wrap_fetch0", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap_decode0", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h01);
        check("wrap_branch0", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 6));
        drive(1'b0, 1'b1, 8'hE1, 1'b0, 8'h00);
        check("wrap_fetch255", e(1, 8'hFF, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 6));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap_decode255", e(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h80);
        check("wrap_branch255", e(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap_fetch1", e(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));

        // HALT ignores stray acks for 20 cycles; only reset leaves it.
        pulse_reset();
        drive(1'b0, 1'b1, 8'hF8, 1'b0, 8'h00);
        check("halt_fetch", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("halt_decode", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0));
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, i[0], 8'h01, ~i[0], 8'h01);
            check($sformatf("halt_hold[%0d]", i),
                  e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3, 0));
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("halt_reset_cycle", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("halt_resume", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // Reset during LD in MEM with the ack in the reset cycle and after.
        pulse_reset();
        drive(1'b0, 1'b1, 8'hAB, 1'b0, 8'h00);
        check("abort_fetch", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("abort_decode", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("abort_mem", e(0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1, 3));
        drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        check("abort_reset_ack", e(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3));
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("abort_after_reset", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("abort_stale_ack", e(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
